// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared constants, key code type and key numbering helper for
//               the 3x3 matrix keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'd0;
    localparam int         NUM_ROWS = 3;
    localparam int         NUM_COLS = 3;

    typedef logic [3:0] key_code_t;

    // Keys are numbered row-major starting at 1: row 0/col 0 = 1, row 2/col 2 = 9.
    function automatic key_code_t key_index(input logic [1:0] row, input logic [1:0] col);
        return key_code_t'(4'd3 * {2'b00, row} + {2'b00, col} + 4'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Whole-matrix debouncer. Accepts a new scan code once it has
//               been seen in DEBOUNCE_SCANS consecutive scans, presents it on
//               key_data and strobes key_valid for newly accepted presses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      scan_done,
    input  key_code_t scan_code,
    output key_code_t key_data,
    output logic      key_valid,
    output logic      key_held
);

    localparam int                c_STB_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_STB_W-1:0] c_STB_MAX = c_STB_W'(DEBOUNCE_SCANS);

    key_code_t          r_cand;
    logic [c_STB_W-1:0] r_stable;
    key_code_t          r_key_data;
    logic               r_key_valid;
    logic               r_key_held;

    logic [c_STB_W-1:0] w_stable_nxt;
    logic               w_accept;

    // Next stability count and acceptance decision for the scan ending now.
    always_comb begin
        w_stable_nxt = c_STB_W'(1);
        if (scan_code == r_cand) begin
            w_stable_nxt = (r_stable == c_STB_MAX) ? c_STB_MAX : r_stable + c_STB_W'(1);
        end
        w_accept = (w_stable_nxt == c_STB_MAX) && (scan_code != r_key_data);
    end

    // Candidate tracking and accepted-key register; clr wipes all history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand      <= KEY_NONE;
            r_stable    <= '0;
            r_key_data  <= KEY_NONE;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else if (clr) begin
            r_cand      <= KEY_NONE;
            r_stable    <= '0;
            r_key_data  <= KEY_NONE;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (scan_done) begin
                r_cand   <= scan_code;
                r_stable <= w_stable_nxt;
                if (w_accept) begin
                    r_key_data  <= scan_code;
                    r_key_valid <= (scan_code != KEY_NONE);
                    r_key_held  <= (scan_code != KEY_NONE);
                end
            end
        end
    end

    assign key_data  = r_key_data;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module      : keypad_scanner
// Description : 3x3 active-low matrix keypad scanner. Drives one column per
//               slot, samples rows at slot end, assembles a 9-bit snapshot
//               and hands the encoded key to the debouncer every full scan.
//               Build option KEYPAD_MULTIKEY_REJECT_EN: multi-key snapshots
//               encode as no key (otherwise the lowest key number wins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SCAN_DIV - 1);

    logic [c_CNT_W-1:0] r_slot_cnt;
    logic [1:0]         r_col;
    logic [8:0]         r_snap;
    logic [2:0]         r_key_col;

    logic               w_tick;
    logic               w_scan_done;
    logic [1:0]         w_col_nxt;
    logic [8:0]         w_snap_full;
    key_code_t          w_scan_code;

    assign w_tick      = en && (r_slot_cnt == c_LAST);
    assign w_scan_done = w_tick && (r_col == 2'd2);
    assign w_col_nxt   = w_tick ? ((r_col == 2'd2) ? 2'd0 : r_col + 2'd1) : r_col;

    // Snapshot with the live row sample merged into the current column (1 = pressed).
    always_comb begin
        w_snap_full = r_snap;
        for (int r = 0; r < NUM_ROWS; r++) begin
            w_snap_full[3*r + int'(r_col)] = ~key_row[r];
        end
    end

    // Encoder: walk keys from highest to lowest so the lowest pressed key is kept.
    always_comb begin
        w_scan_code = KEY_NONE;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            for (int c = NUM_COLS - 1; c >= 0; c--) begin
                if (w_snap_full[3*r + c]) begin
                    w_scan_code = key_index(2'(r), 2'(c));
                end
            end
        end
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        if ((w_snap_full & (w_snap_full - 9'd1)) != 9'd0) begin
            w_scan_code = KEY_NONE;
        end
`endif
    end

    // Slot timer, column index and snapshot; all held at reset values while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
            r_col      <= 2'd0;
            r_snap     <= '0;
        end else if (!en) begin
            r_slot_cnt <= '0;
            r_col      <= 2'd0;
            r_snap     <= '0;
        end else begin
            r_slot_cnt <= w_tick ? '0 : r_slot_cnt + c_CNT_W'(1);
            r_col      <= w_col_nxt;
            if (w_tick) begin
                r_snap <= w_snap_full;
            end
        end
    end

    // Registered column drive so the column changes on the edge after tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_col <= 3'b110;
        end else if (!en) begin
            r_key_col <= 3'b111;
        end else begin
            r_key_col <= ~(3'b001 << w_col_nxt);
        end
    end

    assign key_col = r_key_col;

    key_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (~en),
        .scan_done (w_scan_done),
        .scan_code (w_scan_code),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Scoreboard bench for keypad_scanner with a keypad matrix model
//               and a scan-level reference model of encode and debounce.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int SCAN_CYC = 3 * SD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] key_row;
    logic [2:0] key_col;
    logic [3:0] key_data;
    logic       key_valid;
    logic       key_held;

    logic [8:0] mask;          // physically pressed keys, bit k-1 = key k
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int         at;
        logic [3:0] code;
    } exp_t;
    exp_t exp_q[$];

    int         hist[$];       // encoded code of every scan since the last restart
    int         mdata;         // model's accepted key

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        key_row = 3'b111;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (mask[3*r + c] && !key_col[c]) key_row[r] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_encode(input logic [8:0] m);
        int n;
        int first;
        n = 0;
        first = 0;
        for (int k = 9; k >= 1; k--) begin
            if (m[k-1]) begin
                n++;
                first = k;
            end
        end
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        if (n > 1) first = 0;
`endif
        return first;
    endfunction

    function automatic logic [8:0] key_mask(input int k);
        logic [8:0] one;
        one = 9'd1;
        return one << (k - 1);
    endfunction

    task automatic model_restart();
        hist.delete();
        mdata = 0;
    endtask

    // One full scan with a steady keypad; called at a scan boundary (#1 after the edge).
    task automatic run_scan(input logic [8:0] m);
        int  code;
        bit  steady;
        exp_t e;
        mask = m;
        code = model_encode(m);
        hist.push_back(code);
        steady = (hist.size() >= DB);
        if (steady)
            for (int i = 1; i <= DB; i++)
                if (hist[hist.size()-i] != code) steady = 0;
        if (steady && code != mdata) begin
            mdata = code;
            if (code != 0) begin
                e.at = cyc + SCAN_CYC;
                e.code = 4'(code);
                exp_q.push_back(e);
            end
        end
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk("key_col", int'(key_col), int'(~(3'b001 << s) & 3'b111));
            repeat (SD - 1) @(posedge clk);
        end
        #1;
        chk("key_data", int'(key_data), mdata);
        chk("key_held", int'(key_held), int'(mdata != 0));
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                chk("missed_pulse_cycle", cyc, e.at);
            end
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", int'(key_data), 0);
                    if (key_data == 4'd0) chk("unexpected_pulse_zero", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, e.at);
                    chk("pulse_code", int'(key_data), int'(e.code));
                end
            end
        end
    end

    initial begin
        int sel;
        int hold;
        logic [8:0] m;

        rst_n = 1'b0;
        en    = 1'b1;
        mask  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_col", int'(key_col), 6);
        chk("rst_key_data", int'(key_data), 0);
        chk("rst_key_valid", int'(key_valid), 0);
        chk("rst_key_held", int'(key_held), 0);
        rst_n = 1'b1;
        model_restart();

        // Idle keypad
        repeat (10) run_scan('0);

        // Key 5 held for five scans, then released
        repeat (5) run_scan(key_mask(5));
        repeat (3) run_scan('0);

        // Key 9 bouncing every other scan, then steady
        for (int i = 0; i < 6; i++) run_scan((i % 2 == 0) ? key_mask(9) : 9'd0);
        repeat (4) run_scan(key_mask(9));
        repeat (3) run_scan('0);

        // Keys 2 and 7 together
        repeat (4) run_scan(key_mask(2) | key_mask(7));
        repeat (3) run_scan('0);

        // Direct change 3 -> 5 without release
        repeat (3) run_scan(key_mask(3));
        repeat (3) run_scan(key_mask(5));

        // Key 3 accepted, then enable dropped mid-slot
        repeat (3) run_scan(key_mask(3));
        repeat (6) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk); #1;
        chk("en_off_key_col", int'(key_col), 7);
        chk("en_off_key_data", int'(key_data), 0);
        chk("en_off_key_held", int'(key_held), 0);
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        model_restart();
        repeat (3) run_scan(key_mask(3));
        repeat (2) run_scan('0);

        // Reset while column 2 is driven with key 4 held
        mask = key_mask(4);
        repeat (2 * SD + 1) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_key_col", int'(key_col), 6);
        chk("midrst_key_data", int'(key_data), 0);
        chk("midrst_key_valid", int'(key_valid), 0);
        chk("midrst_key_held", int'(key_held), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        model_restart();
        repeat (3) run_scan(key_mask(4));
        repeat (2) run_scan('0);

        // Randomized key patterns
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      m = '0;
            else if (sel < 8) m = key_mask($urandom_range(1, 9));
            else              m = 9'($urandom_range(0, 511)) | key_mask($urandom_range(1, 9));
            hold = $urandom_range(1, 4);
            repeat (hold) run_scan(m);
        end
        repeat (3) run_scan('0);

        repeat (5) @(posedge clk);
        chk("pending_pulses", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
